// File: rtl/cp0_register_file_pkg.sv
// Shared definitions for the CP0 register block.
//
// wb_stage_params     : layout of the write-back -> CP0 command bus.
// coprocessor_params  : CP0 register/select addresses, Status/Cause field
//                       bit positions and exception-code values.
//
// The WB bus is a per-cycle command with no handshake. Every field is
// sampled on each rising clock edge. write_enabled, exception_valid and
// eret_flush are single-cycle strobes. CP0 always accepts them, so no
// ready or back-pressure signal exists.

package wb_stage_params;

  typedef struct packed {
    logic [4:0]  address_register;
    logic [2:0]  address_select;
    logic        write_enabled;
    logic [31:0] write_data;
    logic        exception_valid;
    logic [31:0] exception_address;
    logic        eret_flush;
    logic        in_delay_slot;
    logic [4:0]  exception_code;
    logic        is_address_fault;
    logic [31:0] badvaddr_value;
    // Handled by the separate TLB register block; CP0 ignores these.
    logic        tlb_read;
    logic        tlb_write;
    logic        tlb_probe;
  } wb_to_cp0_bus_t;

endpackage

package coprocessor_params;

  // Register numbers and the select value used by every implemented register.
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [2:0] CP0_SEL_0        = 3'd0;

  // Packs a (reg,sel) pair into one decode key.
  function automatic logic [7:0] cp0_addr(input logic [4:0] r, input logic [2:0] s);
    return {r, s};
  endfunction

  localparam logic [7:0] ADDR_BADVADDR = {CP0_REG_BADVADDR, CP0_SEL_0};
  localparam logic [7:0] ADDR_COUNT    = {CP0_REG_COUNT,    CP0_SEL_0};
  localparam logic [7:0] ADDR_COMPARE  = {CP0_REG_COMPARE,  CP0_SEL_0};
  localparam logic [7:0] ADDR_STATUS   = {CP0_REG_STATUS,   CP0_SEL_0};
  localparam logic [7:0] ADDR_CAUSE    = {CP0_REG_CAUSE,    CP0_SEL_0};
  localparam logic [7:0] ADDR_EPC      = {CP0_REG_EPC,      CP0_SEL_0};

  // Status fields.
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int STATUS_BEV_BIT = 22;

  // Cause fields.
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_TI_BIT  = 30;
  localparam int CAUSE_BD_BIT  = 31;

  // Exception codes.
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

endpackage

// File: rtl/cp0_register_file_count_timer.sv
// Count/Compare timer for CP0.
//
// Ports:
//   clock, reset      core clock, async active-low reset
//   count_we_i        MTC0 to Count this cycle (already qualified by priority)
//   compare_we_i      MTC0 to Compare this cycle (already qualified)
//   write_data_i      MTC0 write data
//   count_o           registered Count
//   compare_o         registered Compare
//   timer_int_o       Cause.TI
//
// Count advances once every COUNT_TICK_DIVIDER clocks, on the cycle where the
// tick counter wraps. Only divider values 1 and 2 are intended.

module cp0_count_timer #(
  parameter int COUNT_TICK_DIVIDER = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  localparam int TW = (COUNT_TICK_DIVIDER > 1) ? $clog2(COUNT_TICK_DIVIDER) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(COUNT_TICK_DIVIDER - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick_wrap;

  assign tick_wrap = (tick_q == TICK_MAX);

  always_comb begin
    tick_d    = tick_wrap ? '0 : tick_q + TW'(1);
    count_d   = tick_wrap ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    // A software write to Count restarts the tick period as well.
    if (count_we_i) begin
      count_d = write_data_i;
      tick_d  = '0;
    end
    if (compare_we_i) begin
      compare_d = write_data_i;
      ti_d      = 1'b0;   // acknowledge wins over a same-cycle match
    end else if (count_q == compare_q) begin
      ti_d      = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = ti_q;

endmodule

// File: rtl/cp0_register_file.sv
// Coprocessor-0 register block, driven by the write-back stage.
//
// Ports:
//   clock, reset         core clock, async active-low reset
//   wb_to_cp0_data_bus   MTC0 / exception / ERET commands plus MFC0 address
//   cp0_read_data        combinational MFC0 data for the addressed register
//   hw_interrupt         level-sensitive external interrupt lines
//   cp0_epc              EPC (ERET target)
//   cp0_status_exl       Status.EXL
//   interrupt_pending    IE & !EXL & |(Cause.IP & Status.IM)
//
// Per-cycle priority is exception > ERET > MTC0. A lower-priority command
// issued in the same cycle is dropped.

module cp0_register_file
  import wb_stage_params::*;
  import coprocessor_params::*;
#(
  parameter int COUNT_TICK_DIVIDER = 2,
  parameter int HW_INTERRUPT_WIDTH = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  wb_to_cp0_bus_t                wb_to_cp0_data_bus,
  output logic [31:0]                   cp0_read_data,
  input  logic [HW_INTERRUPT_WIDTH-1:0] hw_interrupt,
  output logic [31:0]                   cp0_epc,
  output logic                          cp0_status_exl,
  output logic                          interrupt_pending
);

  // Status / Cause state, kept as individual fields.
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip;
  logic [7:0]  addr;
  logic        do_exc, do_eret, do_mtc0;
  logic        count_we, compare_we;

  // Map the interrupt inputs onto six lines. Narrower buses are zero-extended.
  // Wider buses keep only the low six lines.
  logic [HW_INTERRUPT_WIDTH+5:0] hw_ext;
  logic [5:0]                    hw_lines;
  assign hw_ext   = {6'b0, hw_interrupt};
  assign hw_lines = hw_ext[5:0];

  logic unused_bits;
  assign unused_bits = ^{wb_to_cp0_data_bus.tlb_read, wb_to_cp0_data_bus.tlb_write,
                         wb_to_cp0_data_bus.tlb_probe, hw_ext[HW_INTERRUPT_WIDTH+5:6]};

  assign addr     = cp0_addr(wb_to_cp0_data_bus.address_register,
                             wb_to_cp0_data_bus.address_select);
  assign do_exc   = wb_to_cp0_data_bus.exception_valid;
  assign do_eret  = wb_to_cp0_data_bus.eret_flush & ~do_exc;
  assign do_mtc0  = wb_to_cp0_data_bus.write_enabled & ~do_exc & ~wb_to_cp0_data_bus.eret_flush;

  assign count_we   = do_mtc0 && (addr == ADDR_COUNT);
  assign compare_we = do_mtc0 && (addr == ADDR_COMPARE);

  cp0_count_timer #(
    .COUNT_TICK_DIVIDER(COUNT_TICK_DIVIDER)
  ) u_timer (
    .clock        (clock),
    .reset        (reset),
    .count_we_i   (count_we),
    .compare_we_i (compare_we),
    .write_data_i (wb_to_cp0_data_bus.write_data),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (ti)
  );

  // The timer interrupt shares IP7 with hardware line 5.
  assign ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (do_exc) begin
      exl_d      = 1'b1;
      exc_code_d = wb_to_cp0_data_bus.exception_code;
      if (wb_to_cp0_data_bus.is_address_fault) begin
        badvaddr_d = wb_to_cp0_data_bus.badvaddr_value;
      end
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = wb_to_cp0_data_bus.in_delay_slot ?
                wb_to_cp0_data_bus.exception_address - 32'd4 :
                wb_to_cp0_data_bus.exception_address;
        bd_d  = wb_to_cp0_data_bus.in_delay_slot;
      end
    end else if (do_eret) begin
      exl_d = 1'b0;
    end else if (do_mtc0) begin
      case (addr)
        ADDR_STATUS: begin
          im_d  = wb_to_cp0_data_bus.write_data[STATUS_IM_LSB +: 8];
          exl_d = wb_to_cp0_data_bus.write_data[STATUS_EXL_BIT];
          ie_d  = wb_to_cp0_data_bus.write_data[STATUS_IE_BIT];
        end
        ADDR_CAUSE: ip_sw_d = wb_to_cp0_data_bus.write_data[CAUSE_IP_LSB +: 2];
        ADDR_EPC:   epc_d   = wb_to_cp0_data_bus.write_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= hw_lines;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // MFC0 read: current register state only, no bypass of same-cycle writes.
  always_comb begin
    cp0_read_data = '0;
    case (addr)
      ADDR_BADVADDR: cp0_read_data = badvaddr_q;
      ADDR_COUNT:    cp0_read_data = count;
      ADDR_COMPARE:  cp0_read_data = compare;
      ADDR_STATUS: begin
        cp0_read_data[STATUS_BEV_BIT]       = 1'b1;
        cp0_read_data[STATUS_IM_LSB +: 8]   = im_q;
        cp0_read_data[STATUS_EXL_BIT]       = exl_q;
        cp0_read_data[STATUS_IE_BIT]        = ie_q;
      end
      ADDR_CAUSE: begin
        cp0_read_data[CAUSE_BD_BIT]         = bd_q;
        cp0_read_data[CAUSE_TI_BIT]         = ti;
        cp0_read_data[CAUSE_IP_LSB +: 8]    = ip;
        cp0_read_data[CAUSE_EXC_LSB +: 5]   = exc_code_q;
      end
      ADDR_EPC:      cp0_read_data = epc_q;
      default:       cp0_read_data = '0;
    endcase
  end

  assign cp0_epc           = epc_q;
  assign cp0_status_exl    = exl_q;
  assign interrupt_pending = ie_q & ~exl_q & (|(ip & im_q));

endmodule
